iob_uart_rx_monitor: RTL and testbench

Simulation-side serial receiver that sits directly downstream of the UART16550 sim wrapper's transmit pad (pad_stx_o). It decodes the 8-bit async serial stream back into bytes and pushes them into a FIFO. The bench drains the FIFO over a valid/ready port, with per-byte error flags.
Line timing is set at runtime by a 16550-style divisor (16x oversampling), so the bench can check any baud the DUT is programmed for.

---
 rtl/iob_uart_rx_monitor.sv | 125 ++++++++++++
 tb/tb_iob_uart_rx_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_uart_rx_monitor.sv
// iob_uart_rx_monitor: 16x-oversampled 8-bit async serial receiver feeding a valid/ready FIFO
// Ports: clk_i/arst_i (async high reset)/cke_i (freeze all state when 0), rxd_i serial line,
//   divisor_i clocks per 1/16 bit (0 = receiver off), clr_i clears overrun_o,
//   m_valid_o/m_data_o/m_err_o {break,framing,parity}/m_ready_i FIFO head port,
//   level_o occupancy, overrun_o sticky drop flag, busy_o frame in progress.
// Optional: `define UART_RX_MON_PARITY_EN adds parity_en_i / parity_even_i and the parity bit.
module iob_uart_rx_monitor #(
  parameter int DIV_W = 16,
  parameter int FIFO_AW = 4
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               cke_i,
  input  logic               rxd_i,
  input  logic [DIV_W-1:0]   divisor_i,
  input  logic               clr_i,
  output logic               m_valid_o,
  output logic [7:0]         m_data_o,
  output logic [2:0]         m_err_o,
  input  logic               m_ready_i,
  output logic [FIFO_AW:0]   level_o,
  output logic               overrun_o,
  output logic               busy_o
`ifdef UART_RX_MON_PARITY_EN
  ,
  input  logic               parity_en_i,
  input  logic               parity_even_i
`endif
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t state_q, state_d;
  logic par_en, par_even;
`ifdef UART_RX_MON_PARITY_EN
  assign par_en = parity_en_i;
  assign par_even = parity_even_i;
`else
  assign par_en = 1'b0;
  assign par_even = 1'b0;
`endif
  logic [1:0] sync_q;
  logic rxd, run, tick, sample, push, full, pop, wr_en;
  logic [DIV_W-1:0] cnt_q;
  logic [3:0] scnt_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic pe_q, pbit_q;
  logic [2:0] flags;
  logic [10:0] mem [0:2**FIFO_AW-1];
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW:0] lvl_q;
  assign rxd = sync_q[1];
  assign run = divisor_i != '0;
  assign tick = run && state_q != IDLE && cnt_q == '0;
  assign sample = tick && scnt_q == 4'd7;
  // break needs an all-zero character: data 0x00 and, when present, a 0 parity bit
  assign flags = {!rxd && sh_q == 8'h00 && !(par_en && pbit_q), !rxd, pe_q};
  always_comb begin
    state_d = state_q;
    push = 1'b0;
    case (state_q)
      IDLE:      state_d = rxd ? IDLE : START;
      START:     state_d = !sample ? START : rxd ? IDLE : DATA;
      DATA:      state_d = (sample && bit_q == 3'd7) ? (par_en ? PARITY : STOP) : DATA;
      PARITY:    state_d = sample ? STOP : PARITY;
      STOP: begin
        push = sample;
        state_d = !sample ? STOP : rxd ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: state_d = rxd ? IDLE : WAIT_HIGH;
      default:   state_d = IDLE;
    endcase
    if (!run) state_d = IDLE;
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      cnt_q <= '0;
      scnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      pe_q <= 1'b0;
      pbit_q <= 1'b0;
    end else if (cke_i) begin
      sync_q <= {sync_q[0], rxd_i};
      state_q <= state_d;
      cnt_q <= (state_q == IDLE || tick) ? divisor_i - 1'b1 : cnt_q - 1'b1;
      scnt_q <= (state_q == IDLE) ? 4'd0 : scnt_q + 4'(tick);
      if (state_q == IDLE) begin
        bit_q <= '0;
        pe_q <= 1'b0;
        pbit_q <= 1'b0;
      end else if (sample && state_q == DATA) begin
        sh_q <= {rxd, sh_q[7:1]};
        bit_q <= bit_q + 1'b1;
      end else if (sample && state_q == PARITY) begin
        pbit_q <= rxd;
        pe_q <= rxd != (par_even ? ^sh_q : ~^sh_q);
      end
    end
  end
  assign full = lvl_q[FIFO_AW];
  assign pop = m_valid_o && m_ready_i;
  // when full, a simultaneous pop frees the slot being written (wr_q == rd_q)
  assign wr_en = push && (!full || pop);
  always_ff @(posedge clk_i) if (cke_i && wr_en) mem[wr_q] <= {flags, sh_q};
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      overrun_o <= 1'b0;
    end else if (cke_i) begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      lvl_q <= lvl_q + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(pop);
      overrun_o <= (push && full && !pop) || (overrun_o && !clr_i);
    end
  end
  assign m_valid_o = lvl_q != '0;
  assign m_data_o = m_valid_o ? mem[rd_q][7:0] : 8'h00;
  assign m_err_o = m_valid_o ? mem[rd_q][10:8] : 3'b000;
  assign level_o = lvl_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_iob_uart_rx_monitor.sv
// tb_iob_uart_rx_monitor: randomized self-checking bench for iob_uart_rx_monitor
module tb_iob_uart_rx_monitor;
  logic clk = 1'b0, arst_i = 1'b1, cke_i = 1'b1, rxd_i = 1'b1, clr_i = 1'b0, m_ready_i = 1'b0;
  logic [15:0] divisor_i = 16'd1;
  logic m_valid_o, overrun_o, busy_o;
  logic [7:0] m_data_o;
  logic [2:0] m_err_o;
  logic [4:0] level_o;
`ifdef UART_RX_MON_PARITY_EN
  logic parity_en_i = 1'b0, parity_even_i = 1'b0;
`endif
  int n_checks = 0, n_fail = 0, cyc = 0, rise_cyc = -1, stop_start = 0;
  logic vprev = 1'b0;
  iob_uart_rx_monitor dut (
    .clk_i(clk), .arst_i(arst_i), .cke_i(cke_i), .rxd_i(rxd_i), .divisor_i(divisor_i),
    .clr_i(clr_i), .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_err_o(m_err_o),
    .m_ready_i(m_ready_i), .level_o(level_o), .overrun_o(overrun_o), .busy_o(busy_o)
`ifdef UART_RX_MON_PARITY_EN
    , .parity_en_i(parity_en_i), .parity_even_i(parity_even_i)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (m_valid_o && !vprev) rise_cyc = cyc;
    vprev = m_valid_o;
  end
  function automatic logic [10:0] exp_entry(input logic [7:0] d, input logic pen, input logic peven,
                                            input logic pbit, input logic stopb);
    int ones;
    logic pe, fe, brk;
    ones = $countones(d) + int'(pbit);
    pe = pen && (((ones % 2) == 1) == peven);
    fe = !stopb;
    brk = fe && d == 8'h00 && !(pen && pbit);
    return {brk, fe, pe, d};
  endfunction
  task automatic drive_bit(input logic b, input int n);
    rxd_i = b;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stopb);
    int bt;
    bt = 16 * int'(divisor_i == 0 ? 16'd1 : divisor_i);
    drive_bit(1'b0, bt);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
    if (pen) drive_bit(pbit, bt);
    stop_start = cyc;
    drive_bit(stopb, bt);
    rxd_i = 1'b1;
  endtask
  task automatic pop_entry(output logic got, output logic [10:0] e);
    got = 1'b0;
    e = '0;
    for (int i = 0; i < 4000 && !got; i++) begin
      if (m_valid_o) begin
        got = 1'b1;
        e = {m_err_o, m_data_o};
        m_ready_i = 1'b1;
        @(negedge clk);
        m_ready_i = 1'b0;
      end else @(negedge clk);
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", m_valid_o); end
    if (m_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h exp 00", m_data_o); end
    if (m_err_o !== 3'b000) begin n_fail++; $display("FAIL rst_err got %b exp 000", m_err_o); end
    if (level_o !== 5'd0) begin n_fail++; $display("FAIL rst_level got %0d exp 0", level_o); end
    if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b exp 0", overrun_o); end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    arst_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_single;
    logic got;
    logic [10:0] e;
    divisor_i = 16'd1;
    rise_cyc = -1;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    n_checks += 3;
    if (rise_cyc <= stop_start || rise_cyc > stop_start + 16) begin
      n_fail++; $display("FAIL single_latency valid rose at %0d, stop bit began %0d", rise_cyc, stop_start);
    end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b exp 0", busy_o); end
    pop_entry(got, e);
    if (!got || e !== exp_entry(8'h55, 1'b0, 1'b0, 1'b0, 1'b1)) begin
      n_fail++; $display("FAIL single_entry got %b/%h exp %h", got, e, exp_entry(8'h55, 1'b0, 1'b0, 1'b0, 1'b1));
    end
  endtask
  task automatic test_random;
    logic [10:0] q[$];
    logic [7:0] d;
    logic stopb, got;
    logic [10:0] e;
    divisor_i = 16'($urandom_range(1, 4));
    for (int k = 0; k < 12; k++) begin
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      stopb = $urandom_range(0, 3) != 0;
      send_frame(d, 1'b0, 1'b0, stopb);
      q.push_back(exp_entry(d, 1'b0, 1'b0, 1'b0, stopb));
      repeat ((stopb ? 0 : 16) + 16 * $urandom_range(0, 1) * int'(divisor_i)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (level_o !== 5'(q.size())) begin n_fail++; $display("FAIL rand_level got %0d exp %0d", level_o, q.size()); end
    while (q.size() > 0) begin
      pop_entry(got, e);
      n_checks++;
      if (!got || e !== q[0]) begin n_fail++; $display("FAIL rand_entry got %b/%h exp %h", got, e, q[0]); end
      void'(q.pop_front());
    end
  endtask
  task automatic test_overrun;
    logic got;
    logic [10:0] e;
    divisor_i = 16'd3;
    for (int k = 0; k < 20; k++) send_frame(8'(k), 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    n_checks += 2;
    if (level_o !== 5'd16) begin n_fail++; $display("FAIL ovr_level got %0d exp 16", level_o); end
    if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b exp 1", overrun_o); end
    for (int k = 0; k < 16; k++) begin
      pop_entry(got, e);
      n_checks++;
      if (!got || e !== exp_entry(8'(k), 1'b0, 1'b0, 1'b0, 1'b1)) begin
        n_fail++; $display("FAIL ovr_order idx %0d got %b/%h exp %h", k, got, e, exp_entry(8'(k), 1'b0, 1'b0, 1'b0, 1'b1));
      end
    end
    n_checks += 3;
    if (m_valid_o !== 1'b0 || level_o !== 5'd0) begin n_fail++; $display("FAIL ovr_empty valid %b level %0d exp 0/0", m_valid_o, level_o); end
    if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b exp 1", overrun_o); end
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL ovr_clr got %b exp 0", overrun_o); end
  endtask
  task automatic test_glitch;
    divisor_i = 16'd2;
    rxd_i = 1'b0;
    repeat (8) @(negedge clk);
    n_checks += 3;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hi got %b exp 1", busy_o); end
    repeat (4) @(negedge clk);
    rxd_i = 1'b1;
    repeat (96) @(negedge clk);
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_lo got %b exp 0", busy_o); end
    if (level_o !== 5'd0) begin n_fail++; $display("FAIL glitch_level got %0d exp 0", level_o); end
  endtask
  task automatic test_break;
    logic got;
    logic [10:0] e;
    divisor_i = 16'd1;
    drive_bit(1'b0, 30 * 16);
    n_checks += 4;
    if (level_o !== 5'd1) begin n_fail++; $display("FAIL brk_level_low got %0d exp 1", level_o); end
    drive_bit(1'b1, 32);
    if (level_o !== 5'd1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL brk_after level %0d busy %b exp 1/0", level_o, busy_o); end
    pop_entry(got, e);
    if (!got || e !== exp_entry(8'h00, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL brk_entry got %b/%h exp %h", got, e, exp_entry(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    pop_entry(got, e);
    if (!got || e !== exp_entry(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1)) begin n_fail++; $display("FAIL brk_next got %b/%h", got, e); end
  endtask
  task automatic test_arst;
    logic got;
    logic [10:0] e;
    divisor_i = 16'd2;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 32);
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 16);
    n_checks += 5;
    if (busy_o !== 1'b1 || level_o !== 5'd1) begin n_fail++; $display("FAIL arst_pre busy %b level %0d exp 1/1", busy_o, level_o); end
    arst_i = 1'b1;
    rxd_i = 1'b1;
    #1;
    if (level_o !== 5'd0) begin n_fail++; $display("FAIL arst_level got %0d exp 0", level_o); end
    if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b exp 0", m_valid_o); end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b exp 0", busy_o); end
    repeat (2) @(negedge clk);
    arst_i = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    pop_entry(got, e);
    if (!got || e !== exp_entry(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1)) begin n_fail++; $display("FAIL arst_next got %b/%h", got, e); end
  endtask
  task automatic test_idle_modes;
    divisor_i = 16'd1;
    cke_i = 1'b0;
    send_frame(8'h77, 1'b0, 1'b0, 1'b1);
    cke_i = 1'b1;
    repeat (20) @(negedge clk);
    n_checks += 2;
    if (level_o !== 5'd0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL cke_frozen level %0d busy %b exp 0/0", level_o, busy_o); end
    divisor_i = 16'd0;
    send_frame(8'h77, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    if (level_o !== 5'd0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL div0 level %0d busy %b exp 0/0", level_o, busy_o); end
    divisor_i = 16'd1;
  endtask
`ifdef UART_RX_MON_PARITY_EN
  task automatic test_parity;
    logic got, pb;
    logic [10:0] e;
    logic [7:0] d;
    divisor_i = 16'd1;
    parity_en_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      parity_even_i = (k < 2) ? 1'b1 : 1'($urandom);
      d = (k < 2) ? 8'h03 : 8'($urandom);
      pb = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'($urandom);
      send_frame(d, 1'b1, pb, 1'b1);
      pop_entry(got, e);
      n_checks++;
      if (!got || e !== exp_entry(d, 1'b1, parity_even_i, pb, 1'b1)) begin
        n_fail++; $display("FAIL parity_entry got %b/%h exp %h", got, e, exp_entry(d, 1'b1, parity_even_i, pb, 1'b1));
      end
    end
    parity_en_i = 1'b0;
  endtask
`endif
  initial begin
    test_reset;
    test_single;
    test_random;
    test_overrun;
    test_glitch;
    test_break;
    test_arst;
    test_idle_modes;
`ifdef UART_RX_MON_PARITY_EN
    test_parity;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
